sprite_compositor: RTL
======================

Name: sprite_compositor

Overview:
Parametrised N-sprite pixel compositor that sits between the VGA timing generator and the board RGB/sync pins. It takes pixel coordinates and sync from the timing block, and sprite geometry/colour from game logic. Sprite state is double-buffered: game logic writes a pending set, and the active set swaps in only at frame start. Output is priority-composited RGB plus a static centre separator, per-sprite blink, and a per-frame collision mask against sprite 0, with sync delayed to align with RGB.

Parameters:
N_SPRITES, 3, number of sprites; index 0 has highest priority and is the collision reference
X_W, 10, pixel x width
Y_W, 10, pixel y width
SIZE_W, 6, sprite width/height field width
RGB_W, 12, colour width
H_RES, 640, horizontal visible resolution (separator centring)
SEP_WIDTH, 4, separator width in pixels
SEP_PERIOD_LOG2, 5, log2 of separator dash period in lines
SEP_DOT_H, 16, lit lines per dash period
SEP_OFFSET, 9, vertical phase offset of dashes
BLINK_LOG2, 5, blink half-period is 2^(BLINK_LOG2-1) frames
BG_COLOR, 0, RGB for visible pixels not covered by anything

Ports:
clk_i  in  1  pixel clock
rst_i  in  1  synchronous active-high reset
pixel_x_i  in  X_W  current pixel x from timing generator
pixel_y_i  in  Y_W  current pixel y
visible_i  in  1  pixel is in the visible range
hsync_i  in  1  hsync, active low
vsync_i  in  1  vsync, active low
spr_valid_i  in  1  capture the spr_* buses into the pending set this cycle
spr_x_i  in  N_SPRITES*X_W  sprite left x, sprite k at [k*X_W +: X_W]
spr_y_i  in  N_SPRITES*Y_W  sprite top y
spr_w_i  in  N_SPRITES*SIZE_W  sprite width in pixels
spr_h_i  in  N_SPRITES*SIZE_W  sprite height in pixels
spr_rgb_i  in  N_SPRITES*RGB_W  sprite colour
spr_en_i  in  N_SPRITES  sprite enable
spr_blink_i  in  N_SPRITES  sprite blinks when set
sep_en_i  in  1  separator enable; sampled with the pending set
rgb_o  out  RGB_W  composited colour
hsync_o  out  1  hsync delayed to align with rgb_o
vsync_o  out  1  vsync delayed to align with rgb_o
new_frame_o  out  1  one-cycle frame-start pulse
hit_mask_o  out  N_SPRITES  sprites overlapping sprite 0 during the previous frame; bit 0 is always 0

Behaviour:
- Reset values:
  - rgb_o=0, hsync_o=1, vsync_o=1, new_frame_o=0, hit_mask_o=0.
  - Pending and active sets all 0, so nothing is drawn until the first swap after a write.
  - Blink counter 0. The pipeline valid/sync stages are forced to idle (sync=1, visible=0).
- Pending set:
  - On a cycle with spr_valid_i=1, all spr_* buses and sep_en_i are captured.
  - The last write before a swap wins.
- Frame start:
  - vs_prev <= vsync_i each cycle.
  - new_frame_o <= vs_prev & ~vsync_i (registered falling-edge detect).
- Swap: on a cycle with new_frame_o=1, the active set <= pending set.
  - If spr_valid_i=1 in the same cycle, the pending register takes the new values.
  - The active set takes the old pending values; the new write shows one frame later.
- Blink:
  - A BLINK_LOG2-bit counter increments on new_frame_o and wraps.
  - A sprite with its active blink bit set is hidden while counter MSB=1.
- Pipeline, fixed latency 2 cycles from pixel_x_i/y_i/visible_i/sync inputs to rgb_o/hsync_o/vsync_o.
  - Stage 1 registers, per sprite: hit_k = en_k & ~(blink_k & msb) & x>=sx & x<sx+w & y>=sy & y<sy+h.
    - Sums are computed at X_W+1 / Y_W+1 bits, with no wrap.
    - w=0 or h=0 means never hit.
    - Sprites crossing the screen edge are clipped naturally.
  - Stage 1 also registers sep_hit, visible, hsync, vsync.
  - Stage 1 sep_hit = sep_en & x > H_RES/2-SEP_WIDTH/2 & x < H_RES/2+SEP_WIDTH/2 & ((y+SEP_OFFSET) mod 2^SEP_PERIOD_LOG2) < SEP_DOT_H.
  - Stage 2 registers the output:
    - If not visible: rgb_o=0.
    - Else if sep_hit: rgb_o=all ones (separator overrides sprites).
    - Else the lowest-index hit sprite's colour.
    - Else BG_COLOR.
- Collision:
  - A sticky accumulator sets bit k (k>=1) when stage-1 hit_0 & hit_k & visible.
  - On new_frame_o: hit_mask_o <= accumulator (including a hit in that same cycle), and the accumulator clears.
  - Blinked-off or disabled sprites never collide.
- Reset mid-frame:
  - Outputs return to reset values on the next edge.
  - No new_frame_o pulse is generated until a fresh vsync falling edge after reset deasserts.

Test Plan:
- Reset, then toggle inputs with spr_valid_i=0 through two frames -> rgb_o is 0 in blanking and BG_COLOR in the visible area; hsync_o/vsync_o equal the inputs delayed 2 cycles.
- Write sprite0 at (100,50), 8x8, rgb 0xF00, en=1, then one vsync falling edge -> rgb_o=0xF00 for pixels x 100..107, y 50..57, appearing 2 cycles after the pixel is presented; pixel (108,50) gives BG.
- Sprite0 (0xF00) and sprite1 (0x0F0) both at (200,100), 8x8 -> overlap shows 0xF00; the next frame's hit_mask_o=3'b010.
- Separator with sep_en=1, x=320, y=7: (7+9)&31=16, not <16, so BG; at y=0 the result is 0xFFF, overriding any sprite.
- Write with spr_valid_i=1 in the same cycle as new_frame_o=1 -> the active set keeps the previous pending values for that frame and updates at the next frame start.
- Sprite2 with blink=1, BLINK_LOG2=5 -> visible for frames 0..15 and hidden for frames 16..31, repeating; it never appears in hit_mask_o while hidden.

Source files
------------

// File: rtl/sprite_compositor.sv
`default_nettype none
// ============================================================================
// sprite_compositor : N-sprite priority compositor with double-buffered sprite
// state, centre separator, per-sprite blink and per-frame collision mask.
// Revision 1.0
// ============================================================================
module sprite_compositor #(
  parameter int N_SPRITES       = 3,
  parameter int X_W             = 10,
  parameter int Y_W             = 10,
  parameter int SIZE_W          = 6,
  parameter int RGB_W           = 12,
  parameter int H_RES           = 640,
  parameter int SEP_WIDTH       = 4,
  parameter int SEP_PERIOD_LOG2 = 5,
  parameter int SEP_DOT_H       = 16,
  parameter int SEP_OFFSET      = 9,
  parameter int BLINK_LOG2      = 5,
  parameter logic [RGB_W-1:0] BG_COLOR = '0
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [X_W-1:0]                pixel_x_i,
  input  logic [Y_W-1:0]                pixel_y_i,
  input  logic                          visible_i,
  input  logic                          hsync_i,
  input  logic                          vsync_i,
  input  logic                          spr_valid_i,
  input  logic [N_SPRITES*X_W-1:0]      spr_x_i,
  input  logic [N_SPRITES*Y_W-1:0]      spr_y_i,
  input  logic [N_SPRITES*SIZE_W-1:0]   spr_w_i,
  input  logic [N_SPRITES*SIZE_W-1:0]   spr_h_i,
  input  logic [N_SPRITES*RGB_W-1:0]    spr_rgb_i,
  input  logic [N_SPRITES-1:0]          spr_en_i,
  input  logic [N_SPRITES-1:0]          spr_blink_i,
  input  logic                          sep_en_i,
  output logic [RGB_W-1:0]              rgb_o,
  output logic                          hsync_o,
  output logic                          vsync_o,
  output logic                          new_frame_o,
  output logic [N_SPRITES-1:0]          hit_mask_o
);

  localparam int XV_W = N_SPRITES * X_W;
  localparam int YV_W = N_SPRITES * Y_W;
  localparam int SV_W = N_SPRITES * SIZE_W;
  localparam int CV_W = N_SPRITES * RGB_W;

  localparam logic [X_W:0] SEP_LO = (X_W+1)'(H_RES/2 - SEP_WIDTH/2);
  localparam logic [X_W:0] SEP_HI = (X_W+1)'(H_RES/2 + SEP_WIDTH/2);
  localparam logic [SEP_PERIOD_LOG2-1:0] SEP_OFF = SEP_PERIOD_LOG2'(SEP_OFFSET);
  localparam logic [SEP_PERIOD_LOG2:0]   SEP_DOT = (SEP_PERIOD_LOG2+1)'(SEP_DOT_H);

  // Pending (written by game logic) and active (used for drawing) sets
  logic [XV_W-1:0]      pend_x_q, pend_x_d, act_x_q, act_x_d;
  logic [YV_W-1:0]      pend_y_q, pend_y_d, act_y_q, act_y_d;
  logic [SV_W-1:0]      pend_w_q, pend_w_d, act_w_q, act_w_d;
  logic [SV_W-1:0]      pend_h_q, pend_h_d, act_h_q, act_h_d;
  logic [CV_W-1:0]      pend_rgb_q, pend_rgb_d, act_rgb_q, act_rgb_d;
  logic [N_SPRITES-1:0] pend_en_q, pend_en_d, act_en_q, act_en_d;
  logic [N_SPRITES-1:0] pend_blink_q, pend_blink_d, act_blink_q, act_blink_d;
  logic                 pend_sep_q, pend_sep_d, act_sep_q, act_sep_d;

  logic                  vs_prev_q, vs_prev_d;
  logic                  new_frame_q, new_frame_d;
  logic [BLINK_LOG2-1:0] blink_cnt_q, blink_cnt_d;

  logic [N_SPRITES-1:0] s1_hit_q, s1_hit_d;
  logic                 s1_sep_q, s1_sep_d;
  logic                 s1_vis_q, s1_vis_d;
  logic                 s1_hs_q, s1_hs_d;
  logic                 s1_vs_q, s1_vs_d;

  logic [RGB_W-1:0]     rgb_q, rgb_d;
  logic                 hs_q, hs_d;
  logic                 vs_q, vs_d;

  logic [N_SPRITES-1:0] acc_q, acc_d;
  logic [N_SPRITES-1:0] hit_mask_q, hit_mask_d;

  logic [N_SPRITES-1:0]       hit_now;
  logic                       sep_now;
  logic [SEP_PERIOD_LOG2-1:0] y_phase;
  logic [N_SPRITES-1:0]       coll_now;
  logic [RGB_W-1:0]           rgb_sel;
  logic                       blink_off;

  assign blink_off = blink_cnt_q[BLINK_LOG2-1];

  // Right/bottom edges are formed one bit wider so a sprite near the screen edge never wraps
  for (genvar k = 0; k < N_SPRITES; k++) begin : g_spr
    logic [X_W:0] x_end;
    logic [Y_W:0] y_end;
    logic         in_x;
    logic         in_y;

    assign x_end = {1'b0, act_x_q[k*X_W +: X_W]} + (X_W+1)'(act_w_q[k*SIZE_W +: SIZE_W]);
    assign y_end = {1'b0, act_y_q[k*Y_W +: Y_W]} + (Y_W+1)'(act_h_q[k*SIZE_W +: SIZE_W]);
    assign in_x  = (pixel_x_i >= act_x_q[k*X_W +: X_W]) && ({1'b0, pixel_x_i} < x_end);
    assign in_y  = (pixel_y_i >= act_y_q[k*Y_W +: Y_W]) && ({1'b0, pixel_y_i} < y_end);
    assign hit_now[k] = act_en_q[k] & ~(act_blink_q[k] & blink_off) & in_x & in_y;
  end

  assign y_phase = pixel_y_i[SEP_PERIOD_LOG2-1:0] + SEP_OFF;
  assign sep_now = act_sep_q
                 & ({1'b0, pixel_x_i} > SEP_LO)
                 & ({1'b0, pixel_x_i} < SEP_HI)
                 & ({1'b0, y_phase} < SEP_DOT);

  // Lowest index wins, so scan from the highest index down
  always_comb begin
    rgb_sel = BG_COLOR;
    for (int k = N_SPRITES - 1; k >= 0; k--) begin
      if (s1_hit_q[k]) rgb_sel = act_rgb_q[k*RGB_W +: RGB_W];
    end
  end

  always_comb begin
    coll_now    = s1_hit_q & {N_SPRITES{s1_hit_q[0] & s1_vis_q}};
    coll_now[0] = 1'b0;
  end

  always_comb begin
    pend_x_d     = pend_x_q;
    pend_y_d     = pend_y_q;
    pend_w_d     = pend_w_q;
    pend_h_d     = pend_h_q;
    pend_rgb_d   = pend_rgb_q;
    pend_en_d    = pend_en_q;
    pend_blink_d = pend_blink_q;
    pend_sep_d   = pend_sep_q;
    act_x_d      = act_x_q;
    act_y_d      = act_y_q;
    act_w_d      = act_w_q;
    act_h_d      = act_h_q;
    act_rgb_d    = act_rgb_q;
    act_en_d     = act_en_q;
    act_blink_d  = act_blink_q;
    act_sep_d    = act_sep_q;
    blink_cnt_d  = blink_cnt_q;
    acc_d        = acc_q | coll_now;
    hit_mask_d   = hit_mask_q;

    if (spr_valid_i) begin
      pend_x_d     = spr_x_i;
      pend_y_d     = spr_y_i;
      pend_w_d     = spr_w_i;
      pend_h_d     = spr_h_i;
      pend_rgb_d   = spr_rgb_i;
      pend_en_d    = spr_en_i;
      pend_blink_d = spr_blink_i;
      pend_sep_d   = sep_en_i;
    end

    // Swap takes the pending values as they stood before this cycle's write
    if (new_frame_q) begin
      act_x_d     = pend_x_q;
      act_y_d     = pend_y_q;
      act_w_d     = pend_w_q;
      act_h_d     = pend_h_q;
      act_rgb_d   = pend_rgb_q;
      act_en_d    = pend_en_q;
      act_blink_d = pend_blink_q;
      act_sep_d   = pend_sep_q;
      blink_cnt_d = blink_cnt_q + BLINK_LOG2'(1);
      hit_mask_d  = acc_q | coll_now;
      acc_d       = '0;
    end

    vs_prev_d   = vsync_i;
    new_frame_d = vs_prev_q & ~vsync_i;

    s1_hit_d = hit_now;
    s1_sep_d = sep_now;
    s1_vis_d = visible_i;
    s1_hs_d  = hsync_i;
    s1_vs_d  = vsync_i;

    if (!s1_vis_q)     rgb_d = '0;
    else if (s1_sep_q) rgb_d = '1;
    else               rgb_d = rgb_sel;
    hs_d = s1_hs_q;
    vs_d = s1_vs_q;
  end

  // vs_prev resets low so a vsync already low at reset release is not seen as an edge
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pend_x_q     <= '0;
      pend_y_q     <= '0;
      pend_w_q     <= '0;
      pend_h_q     <= '0;
      pend_rgb_q   <= '0;
      pend_en_q    <= '0;
      pend_blink_q <= '0;
      pend_sep_q   <= 1'b0;
      act_x_q      <= '0;
      act_y_q      <= '0;
      act_w_q      <= '0;
      act_h_q      <= '0;
      act_rgb_q    <= '0;
      act_en_q     <= '0;
      act_blink_q  <= '0;
      act_sep_q    <= 1'b0;
      vs_prev_q    <= 1'b0;
      new_frame_q  <= 1'b0;
      blink_cnt_q  <= '0;
      s1_hit_q     <= '0;
      s1_sep_q     <= 1'b0;
      s1_vis_q     <= 1'b0;
      s1_hs_q      <= 1'b1;
      s1_vs_q      <= 1'b1;
      rgb_q        <= '0;
      hs_q         <= 1'b1;
      vs_q         <= 1'b1;
      acc_q        <= '0;
      hit_mask_q   <= '0;
    end else begin
      pend_x_q     <= pend_x_d;
      pend_y_q     <= pend_y_d;
      pend_w_q     <= pend_w_d;
      pend_h_q     <= pend_h_d;
      pend_rgb_q   <= pend_rgb_d;
      pend_en_q    <= pend_en_d;
      pend_blink_q <= pend_blink_d;
      pend_sep_q   <= pend_sep_d;
      act_x_q      <= act_x_d;
      act_y_q      <= act_y_d;
      act_w_q      <= act_w_d;
      act_h_q      <= act_h_d;
      act_rgb_q    <= act_rgb_d;
      act_en_q     <= act_en_d;
      act_blink_q  <= act_blink_d;
      act_sep_q    <= act_sep_d;
      vs_prev_q    <= vs_prev_d;
      new_frame_q  <= new_frame_d;
      blink_cnt_q  <= blink_cnt_d;
      s1_hit_q     <= s1_hit_d;
      s1_sep_q     <= s1_sep_d;
      s1_vis_q     <= s1_vis_d;
      s1_hs_q      <= s1_hs_d;
      s1_vs_q      <= s1_vs_d;
      rgb_q        <= rgb_d;
      hs_q         <= hs_d;
      vs_q         <= vs_d;
      acc_q        <= acc_d;
      hit_mask_q   <= hit_mask_d;
    end
  end

  assign rgb_o       = rgb_q;
  assign hsync_o     = hs_q;
  assign vsync_o     = vs_q;
  assign new_frame_o = new_frame_q;
  assign hit_mask_o  = hit_mask_q;

endmodule
`default_nettype wire
